mem_access_unit: RTL

- Load/store front end between the CPU memory stage and the byte-addressed data RAM (32-bit word port, little-endian, combinational read, word-only synchronous write).
- Decodes RV32I load/store width (funct3) and sign/zero-extends loads.
- Implements SB/SH as a two-cycle read-modify-write, because the RAM can only write whole words.
- Issues a one-cycle response pulse per accepted request.

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end between the CPU memory stage and a word-write,
// byte-addressed data RAM. Sub-word stores are done as read-modify-write.
module mem_access_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_USED = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             resp_valid_o,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic [WIDTH-1:0] ram_a_o,
  output logic [WIDTH-1:0] ram_wd_o,
  output logic             ram_we_o,
  input  logic [WIDTH-1:0] ram_rd_i
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Address bits above ADDR_USED are passed through untouched; the RAM wraps.
  if (ADDR_USED > WIDTH || WIDTH < 16) begin : g_param_check
    $error("mem_access_unit: need 16 <= WIDTH and ADDR_USED <= WIDTH");
  end

  typedef enum logic [0:0] {S_IDLE, S_RMW_WR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] merged_q, merged_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             accept;
  logic             is_load, is_sw, is_rmw;
  logic [WIDTH-1:0] load_ext;

  // Request decode: legal loads, whole-word stores, sub-word stores.
  always_comb begin
    is_load = !req_we_i && (req_funct3_i == F3_B  || req_funct3_i == F3_H ||
                            req_funct3_i == F3_W  || req_funct3_i == F3_BU ||
                            req_funct3_i == F3_HU);
    is_sw   = req_we_i && (req_funct3_i == F3_W);
    is_rmw  = req_we_i && (req_funct3_i == F3_B || req_funct3_i == F3_H);
  end

  // Load data extension of the RAM read word.
  always_comb begin
    load_ext = ram_rd_i;
    case (req_funct3_i)
      F3_B:    load_ext = {{(WIDTH-8){ram_rd_i[7]}}, ram_rd_i[7:0]};
      F3_H:    load_ext = {{(WIDTH-16){ram_rd_i[15]}}, ram_rd_i[15:0]};
      F3_BU:   load_ext = {{(WIDTH-8){1'b0}}, ram_rd_i[7:0]};
      F3_HU:   load_ext = {{(WIDTH-16){1'b0}}, ram_rd_i[15:0]};
      default: load_ext = ram_rd_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && is_rmw) state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs toward requester and RAM; everything held low during reset.
  always_comb begin
    req_ready_o = 1'b0;
    ram_a_o     = '0;
    ram_wd_o    = '0;
    ram_we_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_IDLE: begin
          req_ready_o = 1'b1;
          ram_a_o     = req_addr_i;
          ram_wd_o    = req_wdata_i;
          ram_we_o    = req_valid_i && is_sw;
        end
        S_RMW_WR: begin
          ram_a_o  = addr_q;
          ram_wd_o = merged_q;
          ram_we_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign accept = req_valid_i && req_ready_o;

  // Response and RMW datapath next values.
  always_comb begin
    addr_d       = addr_q;
    merged_d     = merged_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    if (state_q == S_RMW_WR) begin
      resp_valid_d = 1'b1;
    end else if (accept) begin
      if (is_rmw) begin
        addr_d   = req_addr_i;
        merged_d = (req_funct3_i == F3_B) ? {ram_rd_i[WIDTH-1:8], req_wdata_i[7:0]}
                                          : {ram_rd_i[WIDTH-1:16], req_wdata_i[15:0]};
      end else begin
        resp_valid_d = 1'b1;
        resp_err_d   = !(is_load || is_sw);
        if (is_load) resp_rdata_d = load_ext;
      end
    end
  end

  // Datapath registers; reset drops any pending RMW response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      merged_q     <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      merged_q     <= merged_d;
      resp_rdata_q <= resp_rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule
